// File: rtl/div_sign_ctrl_pkg.sv
// Shared definitions for the RV32M divider sign-control wrapper:
// op encodings, per-op metadata flags and the default divider depth.
package div_sign_ctrl_pkg;

   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } div_op_e;

   localparam int DIV_LATENCY = 8;
   localparam int DIV_TAG_W   = 5;

   typedef struct packed {
      logic is_rem;
      logic neg_q;
      logic neg_r;
      logic dz;
   } div_meta_flags_t;

   localparam int META_FLAGS_W = $bits(div_meta_flags_t);

   function automatic logic is_signed_op(input div_op_e op);
      return (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/div_meta_pipe.sv
// Valid + payload shift register whose depth matches the divider, so the
// last stage lines up with the divider result every cycle.
module div_meta_pipe #(
   parameter int LATENCY = 8,
   parameter int W       = 9
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   output logic [W-1:0] out_data
);

   logic [LATENCY-1:0] valid_q;
   logic [W-1:0]       data_q [LATENCY];

   always_ff @(posedge clk) begin
      if (clear) begin
         valid_q <= '0;
      end else begin
         valid_q[0] <= in_valid;
         for (int k = 1; k < LATENCY; k++) begin
            valid_q[k] <= valid_q[k-1];
         end
      end
   end

   // Payload is qualified by valid_q, so it needs no clear.
   always_ff @(posedge clk) begin
      data_q[0] <= in_data;
      for (int k = 1; k < LATENCY; k++) begin
         data_q[k] <= data_q[k-1];
      end
   end

   assign out_valid = valid_q[LATENCY-1];
   assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/div_sign_ctrl.sv
// Signed/unsigned wrapper around the pipelined unsigned divider: converts
// operands to magnitudes, tracks per-op metadata and applies sign/div-by-zero fixup.
module div_sign_ctrl
   import div_sign_ctrl_pkg::*;
#(
   parameter int LATENCY = DIV_LATENCY,
   parameter int TAG_W   = DIV_TAG_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         i_valid,
   input  logic [1:0]                   i_op,
   input  logic [31:0]                  i_a,
   input  logic [31:0]                  i_b,
   input  logic [TAG_W-1:0]             i_tag,
   output logic [31:0]                  o_div_dividend,
   output logic [31:0]                  o_div_divisor,
   input  logic [31:0]                  i_div_quotient,
   input  logic [31:0]                  i_div_remainder,
   output logic                         o_valid,
   output logic [31:0]                  o_result,
   output logic [TAG_W-1:0]             o_tag,
   output logic                         o_busy,
   output logic [$clog2(LATENCY+1)-1:0] o_inflight
);

   localparam int CNT_W  = $clog2(LATENCY+1);
   localparam int META_W = TAG_W + META_FLAGS_W;

   logic            is_signed;
   logic            sa;
   logic            sb;
   logic            b_zero;
   div_meta_flags_t req_flags;
   div_meta_flags_t ret_flags;
   logic [META_W-1:0] req_meta;
   logic [META_W-1:0] ret_meta;
   logic [TAG_W-1:0]  ret_tag;
   logic            ret_valid;
   logic            accept;
   logic            retire;
   logic [31:0]     result_next;

   always_comb begin
      is_signed = is_signed_op(div_op_e'(i_op));
      sa        = is_signed & i_a[31];
      sb        = is_signed & i_b[31];
      b_zero    = (i_b == 32'd0);

      o_div_dividend = '0;
      o_div_divisor  = '0;
      if (i_valid) begin
         o_div_dividend = sa ? -i_a : i_a;
         o_div_divisor  = sb ? -i_b : i_b;
      end

      req_flags.is_rem = i_op[1];
      req_flags.neg_q  = is_signed & (sa ^ sb) & ~b_zero;
      req_flags.neg_r  = sa;
      req_flags.dz     = b_zero;
   end

   assign req_meta = {i_tag, req_flags};

   div_meta_pipe #(
      .LATENCY (LATENCY),
      .W       (META_W)
   ) u_meta_pipe (
      .clk       (clk),
      .clear     (rst | flush),
      .in_valid  (i_valid),
      .in_data   (req_meta),
      .out_valid (ret_valid),
      .out_data  (ret_meta)
   );

   assign {ret_tag, ret_flags} = ret_meta;

   assign accept = i_valid & ~flush;
   assign retire = ret_valid & ~flush;

   // Dividend-sign remainder also covers div-by-zero (rem = dividend).
   always_comb begin
      if (ret_flags.is_rem)
         result_next = ret_flags.neg_r ? -i_div_remainder : i_div_remainder;
      else if (ret_flags.dz)
         result_next = 32'hFFFF_FFFF;
      else
         result_next = ret_flags.neg_q ? -i_div_quotient : i_div_quotient;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         o_valid  <= 1'b0;
         o_result <= '0;
         o_tag    <= '0;
      end else if (retire) begin
         o_valid  <= 1'b1;
         o_result <= result_next;
         o_tag    <= ret_tag;
      end else begin
         o_valid  <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         o_inflight <= '0;
      end else if (accept && !retire && (o_inflight < CNT_W'(LATENCY))) begin
         o_inflight <= o_inflight + 1'b1;
      end else if (!accept && retire && (o_inflight != '0)) begin
         o_inflight <= o_inflight - 1'b1;
      end
   end

   assign o_busy = (o_inflight != '0);

endmodule

// File: tb/tb_div_sign_ctrl.sv
// Directed bench for div_sign_ctrl with a behavioural 8-deep unsigned divider.
module tb_div_sign_ctrl;
   import div_sign_ctrl_pkg::*;

   localparam int LAT = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        i_valid;
   logic [1:0]  i_op;
   logic [31:0] i_a;
   logic [31:0] i_b;
   logic [4:0]  i_tag;
   logic [31:0] o_div_dividend;
   logic [31:0] o_div_divisor;
   logic [31:0] i_div_quotient;
   logic [31:0] i_div_remainder;
   logic        o_valid;
   logic [31:0] o_result;
   logic [4:0]  o_tag;
   logic        o_busy;
   logic [3:0]  o_inflight;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      int          cyc;
      logic [31:0] res;
      logic [4:0]  tag;
   } rec_t;

   rec_t exp_q[$];
   rec_t obs_q[$];

   logic [31:0] q_pipe [LAT];
   logic [31:0] r_pipe [LAT];

   logic [1:0]  a_op  [10] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_DIVU,
                               OP_REM, OP_REMU, OP_DIV, OP_REM};
   logic [31:0] a_a   [10] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5,
                               32'd5, 32'hFFFFFFFB, 32'd7, 32'h80000000, 32'h80000000};
   logic [31:0] a_b   [10] = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0,
                               32'hFFFFFFFF, 32'hFFFFFFFF};
   logic [31:0] a_dvd [10] = '{32'd7, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd5,
                               32'd5, 32'd7, 32'h80000000, 32'h80000000};
   logic [31:0] a_dvs [10] = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0,
                               32'd1, 32'd1};
   logic [31:0] a_exp [10] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'd1, 32'hFFFFFFFF,
                               32'hFFFFFFFF, 32'hFFFFFFFB, 32'd7, 32'h80000000, 32'd0};

   div_sign_ctrl #(.LATENCY(LAT), .TAG_W(5)) dut (
      .clk             (clk),
      .rst             (rst),
      .flush           (flush),
      .i_valid         (i_valid),
      .i_op            (i_op),
      .i_a             (i_a),
      .i_b             (i_b),
      .i_tag           (i_tag),
      .o_div_dividend  (o_div_dividend),
      .o_div_divisor   (o_div_divisor),
      .i_div_quotient  (i_div_quotient),
      .i_div_remainder (i_div_remainder),
      .o_valid         (o_valid),
      .o_result        (o_result),
      .o_tag           (o_tag),
      .o_busy          (o_busy),
      .o_inflight      (o_inflight)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Unsigned divider with RISC-V div-by-zero behaviour: q = all ones, r = dividend.
   always @(posedge clk) begin
      q_pipe[0] <= (o_div_divisor == 32'd0) ? 32'hFFFFFFFF : o_div_dividend / o_div_divisor;
      r_pipe[0] <= (o_div_divisor == 32'd0) ? o_div_dividend : o_div_dividend % o_div_divisor;
      for (int k = 1; k < LAT; k++) begin
         q_pipe[k] <= q_pipe[k-1];
         r_pipe[k] <= r_pipe[k-1];
      end
   end

   assign i_div_quotient  = q_pipe[LAT-1];
   assign i_div_remainder = r_pipe[LAT-1];

   always @(negedge clk) begin
      if (o_valid) obs_q.push_back('{cyc: cyc, res: o_result, tag: o_tag});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] tag);
      i_valid = v;
      i_op    = op;
      i_a     = a;
      i_b     = b;
      i_tag   = tag;
      #1;
   endtask

   task automatic issueOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input logic [31:0] res);
      exp_q.push_back('{cyc: cyc + LAT + 1, res: res, tag: tag});
      applyStimulus(1'b1, op, a, b, tag);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("[TB] FAIL %s: got %h expected %h", name, obs, expv);
      end
   endtask

   task automatic compareResults();
      rec_t e;
      rec_t o;
      checkOutput("result_count", obs_q.size(), exp_q.size());
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checkOutput("result_value", o.res, e.res);
         checkOutput("result_tag", 32'(o.tag), 32'(e.tag));
         checkOutput("result_cycle", o.cyc, e.cyc);
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   initial begin
      rst   = 1'b1;
      flush = 1'b0;
      applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
      tick();
      tick();
      checkOutput("rst_valid", o_valid, 1'b0);
      checkOutput("rst_result", o_result, 32'd0);
      checkOutput("rst_tag", 32'(o_tag), 32'd0);
      checkOutput("rst_inflight", 32'(o_inflight), 32'd0);
      checkOutput("rst_busy", o_busy, 1'b0);
      rst = 1'b0;
      tick();

      $display("[TB] back-to-back mixed ops");
      for (int i = 0; i < 10; i++) begin
         issueOp(a_op[i], a_a[i], a_b[i], 5'(i), a_exp[i]);
         checkOutput("mag_dividend", o_div_dividend, a_dvd[i]);
         checkOutput("mag_divisor", o_div_divisor, a_dvs[i]);
         tick();
         checkOutput("inflight_ramp", 32'(o_inflight), (i + 1 > LAT) ? LAT : i + 1);
      end
      applyStimulus(1'b0, OP_DIV, 32'hFFFFFFF9, 32'd3, 5'd0);
      checkOutput("idle_dividend", o_div_dividend, 32'd0);
      checkOutput("idle_divisor", o_div_divisor, 32'd0);
      repeat (7) tick();
      checkOutput("busy_before_last", o_busy, 1'b1);
      checkOutput("inflight_last", 32'(o_inflight), 32'd1);
      tick();
      checkOutput("last_valid", o_valid, 1'b1);
      checkOutput("busy_after_last", o_busy, 1'b0);
      checkOutput("inflight_drained", 32'(o_inflight), 32'd0);
      repeat (2) tick();
      compareResults();

      $display("[TB] flush with ops in flight");
      applyStimulus(1'b1, OP_DIV, 32'd9, 32'd3, 5'd0);
      tick();
      applyStimulus(1'b1, OP_REM, 32'd9, 32'd4, 5'd1);
      tick();
      applyStimulus(1'b1, OP_DIVU, 32'd8, 32'd2, 5'd2);
      tick();
      applyStimulus(1'b0, OP_DIV, 32'd0, 32'd0, 5'd0);
      tick();
      checkOutput("inflight_pre_flush", 32'(o_inflight), 32'd3);
      flush = 1'b1;
      applyStimulus(1'b1, OP_DIV, 32'd50, 32'd5, 5'd9);
      tick();
      flush = 1'b0;
      checkOutput("flush_inflight", 32'(o_inflight), 32'd0);
      checkOutput("flush_busy", o_busy, 1'b0);
      checkOutput("flush_valid", o_valid, 1'b0);
      issueOp(OP_DIVU, 32'd100, 32'd7, 5'd3, 32'd14);
      tick();
      applyStimulus(1'b0, OP_DIV, 32'd0, 32'd0, 5'd0);
      repeat (11) tick();
      compareResults();
      checkOutput("hold_result", o_result, 32'd14);

      $display("[TB] flush on retire edge");
      applyStimulus(1'b1, OP_DIV, 32'd20, 32'd4, 5'd4);
      tick();
      applyStimulus(1'b0, OP_DIV, 32'd0, 32'd0, 5'd0);
      repeat (7) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checkOutput("suppress_valid", o_valid, 1'b0);
      checkOutput("suppress_hold", o_result, 32'd14);
      checkOutput("suppress_inflight", 32'(o_inflight), 32'd0);
      repeat (3) tick();
      compareResults();

      $display("[TB] reset with ops in flight");
      applyStimulus(1'b1, OP_DIV, 32'd9, 32'd3, 5'd5);
      tick();
      applyStimulus(1'b1, OP_REMU, 32'd9, 32'd4, 5'd6);
      tick();
      applyStimulus(1'b1, OP_DIV, 32'd8, 32'd2, 5'd7);
      tick();
      applyStimulus(1'b0, OP_DIV, 32'd0, 32'd0, 5'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("mid_rst_valid", o_valid, 1'b0);
      checkOutput("mid_rst_result", o_result, 32'd0);
      checkOutput("mid_rst_inflight", 32'(o_inflight), 32'd0);
      checkOutput("mid_rst_busy", o_busy, 1'b0);
      issueOp(OP_REM, 32'hFFFFFF9C, 32'd7, 5'd8, 32'hFFFFFFFE);
      tick();
      applyStimulus(1'b0, OP_DIV, 32'd0, 32'd0, 5'd0);
      repeat (11) tick();
      compareResults();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
